// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// | Module   : decode_queue                                                  |
// | Purpose  : RV32I pre-decode FIFO between fetch and issue. Instructions  |
// |            are decoded on entry and held decoded in queue storage.      |
// | Options  : DECODE_ILLEGAL_TRAP_EN - build illegal-encoding flag path    |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

package decode_queue_pkg;
  typedef enum logic [5:0] {
    OPC_NOP   = 6'd0,
    OPC_LUI   = 6'd1,
    OPC_AUIPC = 6'd2,
    OPC_JAL   = 6'd3,
    OPC_JALR  = 6'd4,
    OPC_BEQ   = 6'd5,
    OPC_BNE   = 6'd6,
    OPC_BLT   = 6'd7,
    OPC_BGE   = 6'd8,
    OPC_BLTU  = 6'd9,
    OPC_BGEU  = 6'd10,
    OPC_LB    = 6'd11,
    OPC_LH    = 6'd12,
    OPC_LW    = 6'd13,
    OPC_LBU   = 6'd14,
    OPC_LHU   = 6'd15,
    OPC_SB    = 6'd16,
    OPC_SH    = 6'd17,
    OPC_SW    = 6'd18,
    OPC_ADDI  = 6'd19,
    OPC_SLTI  = 6'd20,
    OPC_SLTIU = 6'd21,
    OPC_XORI  = 6'd22,
    OPC_ORI   = 6'd23,
    OPC_ANDI  = 6'd24,
    OPC_SLLI  = 6'd25,
    OPC_SRLI  = 6'd26,
    OPC_SRAI  = 6'd27,
    OPC_ADD   = 6'd28,
    OPC_SUB   = 6'd29,
    OPC_SLL   = 6'd30,
    OPC_SLT   = 6'd31,
    OPC_SLTU  = 6'd32,
    OPC_XOR   = 6'd33,
    OPC_SRL   = 6'd34,
    OPC_SRA   = 6'd35,
    OPC_OR    = 6'd36,
    OPC_AND   = 6'd37,
    OPC_ECALL = 6'd38,
    OPC_EBREAK = 6'd39
  } opcode_out_t;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output opcode_out_t                out_opcode,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [31:0]                out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_imm    = 7'b0010011;
  localparam logic [6:0] c_opc_reg    = 7'b0110011;
  localparam logic [6:0] c_opc_system = 7'b1110011;
  localparam logic [31:0] c_word_ecall  = 32'h0000_0073;
  localparam logic [31:0] c_word_ebreak = 32'h0010_0073;

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  opcode_out_t     r_op_mem    [DEPTH];
  logic [4:0]      r_rd_mem    [DEPTH];
  logic [4:0]      r_rs1_mem   [DEPTH];
  logic [4:0]      r_rs2_mem   [DEPTH];
  logic [31:0]     r_instr_mem [DEPTH];
  logic [PC_W-1:0] r_pc_mem    [DEPTH];

  logic            w_push;
  logic            w_pop;
  opcode_out_t     w_dec_op;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;

  assign in_ready  = (r_count < c_depth);
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  // Reserved funct3/funct7 combinations fall through to the NOP default.
  always_comb begin
    w_dec_op = OPC_NOP;
    case (in_instr[6:0])
      c_opc_lui:   w_dec_op = OPC_LUI;
      c_opc_auipc: w_dec_op = OPC_AUIPC;
      c_opc_jal:   w_dec_op = OPC_JAL;
      c_opc_jalr:  w_dec_op = OPC_JALR;
      c_opc_branch: begin
        case (w_funct3)
          3'b000:  w_dec_op = OPC_BEQ;
          3'b001:  w_dec_op = OPC_BNE;
          3'b100:  w_dec_op = OPC_BLT;
          3'b101:  w_dec_op = OPC_BGE;
          3'b110:  w_dec_op = OPC_BLTU;
          3'b111:  w_dec_op = OPC_BGEU;
          default: w_dec_op = OPC_NOP;
        endcase
      end
      c_opc_load: begin
        case (w_funct3)
          3'b000:  w_dec_op = OPC_LB;
          3'b001:  w_dec_op = OPC_LH;
          3'b010:  w_dec_op = OPC_LW;
          3'b100:  w_dec_op = OPC_LBU;
          3'b101:  w_dec_op = OPC_LHU;
          default: w_dec_op = OPC_NOP;
        endcase
      end
      c_opc_store: begin
        case (w_funct3)
          3'b000:  w_dec_op = OPC_SB;
          3'b001:  w_dec_op = OPC_SH;
          3'b010:  w_dec_op = OPC_SW;
          default: w_dec_op = OPC_NOP;
        endcase
      end
      c_opc_imm: begin
        case (w_funct3)
          3'b000:  w_dec_op = OPC_ADDI;
          3'b010:  w_dec_op = OPC_SLTI;
          3'b011:  w_dec_op = OPC_SLTIU;
          3'b100:  w_dec_op = OPC_XORI;
          3'b110:  w_dec_op = OPC_ORI;
          3'b111:  w_dec_op = OPC_ANDI;
          3'b001:  w_dec_op = (w_funct7 == 7'h00) ? OPC_SLLI : OPC_NOP;
          3'b101: begin
            if (w_funct7 == 7'h00)      w_dec_op = OPC_SRLI;
            else if (w_funct7 == 7'h20) w_dec_op = OPC_SRAI;
            else                        w_dec_op = OPC_NOP;
          end
          default: w_dec_op = OPC_NOP;
        endcase
      end
      c_opc_reg: begin
        if (w_funct7 == 7'h00) begin
          case (w_funct3)
            3'b000:  w_dec_op = OPC_ADD;
            3'b001:  w_dec_op = OPC_SLL;
            3'b010:  w_dec_op = OPC_SLT;
            3'b011:  w_dec_op = OPC_SLTU;
            3'b100:  w_dec_op = OPC_XOR;
            3'b101:  w_dec_op = OPC_SRL;
            3'b110:  w_dec_op = OPC_OR;
            3'b111:  w_dec_op = OPC_AND;
            default: w_dec_op = OPC_NOP;
          endcase
        end else if (w_funct7 == 7'h20) begin
          if (w_funct3 == 3'b000)      w_dec_op = OPC_SUB;
          else if (w_funct3 == 3'b101) w_dec_op = OPC_SRA;
          else                         w_dec_op = OPC_NOP;
        end
      end
      c_opc_system: begin
        if (in_instr == c_word_ecall)       w_dec_op = OPC_ECALL;
        else if (in_instr == c_word_ebreak) w_dec_op = OPC_EBREAK;
        else                                w_dec_op = OPC_NOP;
      end
      default: w_dec_op = OPC_NOP;
    endcase
  end

  // Entry storage is deliberately left unreset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr]    <= w_dec_op;
      r_rd_mem[r_wr_ptr]    <= in_instr[11:7];
      r_rs1_mem[r_wr_ptr]   <= in_instr[19:15];
      r_rs2_mem[r_wr_ptr]   <= in_instr[24:20];
      r_instr_mem[r_wr_ptr] <= in_instr;
      r_pc_mem[r_wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_opcode = r_op_mem[r_rd_ptr];
  assign out_rd     = r_rd_mem[r_rd_ptr];
  assign out_rs1    = r_rs1_mem[r_rd_ptr];
  assign out_rs2    = r_rs2_mem[r_rd_ptr];
  assign out_instr  = r_instr_mem[r_rd_ptr];
  assign out_pc     = r_pc_mem[r_rd_ptr];

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic r_illegal_mem [DEPTH];
  logic w_dec_illegal;

  // The canonical NOP is ADDI x0,x0,0 and is never flagged.
  assign w_dec_illegal = (w_dec_op == OPC_NOP) && (in_instr != 32'h0000_0013);

  always_ff @(posedge clk) begin
    if (w_push) r_illegal_mem[r_wr_ptr] <= w_dec_illegal;
  end

  assign out_illegal = out_valid && r_illegal_mem[r_rd_ptr];
`else
  assign out_illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: decode vector table plus queue
// occupancy, wrap, flush and reset sequences.
`default_nettype none

module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NVEC  = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  opcode_out_t       out_opcode;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [31:0]       out_instr;
  logic [PC_W-1:0]   out_pc;
  logic              out_illegal;
  logic [CW-1:0]     count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    opcode_out_t op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  vec_t vecs [NVEC];

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_illegal (out_illegal),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic logic exp_illegal(input vec_t v);
`ifdef DECODE_ILLEGAL_TRAP_EN
    return (v.op == OPC_NOP) && (v.instr != 32'h0000_0013);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    logic [PC_W-1:0] q [$];
    logic [PC_W-1:0] next_pc;

    vecs[0]  = '{32'h00A0_0093, OPC_ADDI,   5'd1,  5'd0,  5'd10};
    vecs[1]  = '{32'h4000_5033, OPC_SRA,    5'd0,  5'd0,  5'd0};
    vecs[2]  = '{32'h0020_A023, OPC_SW,     5'd0,  5'd1,  5'd2};
    vecs[3]  = '{32'hFE00_0033, OPC_NOP,    5'd0,  5'd0,  5'd0};
    vecs[4]  = '{32'h0000_0073, OPC_ECALL,  5'd0,  5'd0,  5'd0};
    vecs[5]  = '{32'h0010_0073, OPC_EBREAK, 5'd0,  5'd0,  5'd1};
    vecs[6]  = '{32'h0000_0013, OPC_ADDI,   5'd0,  5'd0,  5'd0};
    vecs[7]  = '{32'h1234_50B7, OPC_LUI,    5'd1,  5'd8,  5'd3};
    vecs[8]  = '{32'h0020_9463, OPC_BNE,    5'd8,  5'd1,  5'd2};
    vecs[9]  = '{32'h0000_D103, OPC_LHU,    5'd2,  5'd1,  5'd0};
    vecs[10] = '{32'h0000_3003, OPC_NOP,    5'd0,  5'd0,  5'd0};
    vecs[11] = '{32'h4000_1013, OPC_NOP,    5'd0,  5'd0,  5'd0};
    vecs[12] = '{32'h4000_0033, OPC_SUB,    5'd0,  5'd0,  5'd0};
    vecs[13] = '{32'h0000_80E7, OPC_JALR,   5'd1,  5'd1,  5'd0};
    vecs[14] = '{32'hFFFF_FFFF, OPC_NOP,    5'd31, 5'd31, 5'd31};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #2;
    chk("reset_count",     32'(count),       32'd0);
    chk("reset_out_valid", 32'(out_valid),   32'd0);
    chk("reset_in_ready",  32'(in_ready),    32'd1);
    chk("reset_illegal",   32'(out_illegal), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Decode table: each word pushed into an empty queue, checked at head, popped.
    for (int i = 0; i < NVEC; i++) begin
      push_word(vecs[i].instr, PC_W'(32'h100 + 4 * i));
      chk("vec_valid",   32'(out_valid),   32'd1);
      chk("vec_opcode",  32'(out_opcode),  32'(vecs[i].op));
      chk("vec_rd",      32'(out_rd),      32'(vecs[i].rd));
      chk("vec_rs1",     32'(out_rs1),     32'(vecs[i].rs1));
      chk("vec_rs2",     32'(out_rs2),     32'(vecs[i].rs2));
      chk("vec_instr",   out_instr,        vecs[i].instr);
      chk("vec_pc",      32'(out_pc),      32'h100 + 4 * i);
      chk("vec_illegal", 32'(out_illegal), 32'(exp_illegal(vecs[i])));
      pop_one();
      chk("vec_drained", 32'(count),       32'd0);
    end

    // Pop while empty is ignored.
    pop_one();
    chk("empty_pop_count", 32'(count), 32'd0);
    chk("empty_pop_valid", 32'(out_valid), 32'd0);

    // Fill to DEPTH, then offer one more word that must be refused.
    for (int i = 0; i < DEPTH; i++) push_word(32'h0000_0013, PC_W'(32'h400 + 4 * i));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count",    32'(count),    DEPTH);
    push_word(32'h0000_0033, PC_W'(32'hBAD));
    chk("full_push_blocked", 32'(count), DEPTH);
    chk("full_head_pc",      32'(out_pc), 32'h400);
    pop_one();
    chk("after_pop_in_ready", 32'(in_ready), 32'd1);
    chk("after_pop_count",    32'(count),    DEPTH - 1);
    for (int i = 1; i < DEPTH; i++) begin
      chk("full_drain_pc", 32'(out_pc), 32'h400 + 4 * i);
      pop_one();
    end
    chk("full_drained", 32'(count), 32'd0);

    // Streaming push+pop across pointer wrap with a steady occupancy of 2.
    push_word(32'h0000_0013, PC_W'(32'h200));
    push_word(32'h0000_0013, PC_W'(32'h204));
    q = {PC_W'(32'h200), PC_W'(32'h204)};
    next_pc = PC_W'(32'h208);
    for (int k = 0; k < 3 * DEPTH; k++) begin
      in_instr = 32'h0000_0013; in_pc = next_pc;
      in_valid = 1'b1; out_ready = 1'b1;
      chk("stream_head_pc", 32'(out_pc), 32'(q[0]));
      chk("stream_count",   32'(count),  32'd2);
      step();
      void'(q.pop_front());
      q.push_back(next_pc);
      next_pc = next_pc + 4;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    while (q.size() != 0) begin
      chk("stream_tail_pc", 32'(out_pc), 32'(q[0]));
      void'(q.pop_front());
      pop_one();
    end
    chk("stream_empty", 32'(out_valid), 32'd0);

    // Flush with three entries queued and a same-cycle push.
    for (int i = 0; i < 3; i++) push_word(32'h0000_0013, PC_W'(32'h500 + 4 * i));
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h4000_0033; in_pc = PC_W'(32'h5FC);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count",    32'(count),     32'd0);
    chk("flush_valid",    32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready),  32'd1);
    push_word(32'h0020_A023, PC_W'(32'h600));
    chk("post_flush_pc",    32'(out_pc),     32'h600);
    chk("post_flush_op",    32'(out_opcode), 32'(OPC_SW));
    chk("post_flush_count", 32'(count),      32'd1);
    pop_one();

    // Asynchronous reset mid-transfer discards all entries.
    push_word(32'hFE00_0033, PC_W'(32'h700));
    push_word(32'h0000_0013, PC_W'(32'h704));
    in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = PC_W'(32'h708);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count",   32'(count),       32'd0);
    chk("async_rst_valid",   32'(out_valid),   32'd0);
    chk("async_rst_ready",   32'(in_ready),    32'd1);
    chk("async_rst_illegal", 32'(out_illegal), 32'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    push_word(32'h00A0_0093, PC_W'(32'h800));
    chk("post_rst_count", 32'(count),      32'd1);
    chk("post_rst_pc",    32'(out_pc),     32'h800);
    chk("post_rst_op",    32'(out_opcode), 32'(OPC_ADDI));
    pop_one();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
